// File: rtl/seven_seg_pkg.sv
// Shared encodings for the seven-segment scan controller: page select codes
// and active-low segment constants.
package seven_seg_pkg;

  typedef enum logic [1:0] {
    PAGE_LO    = 2'b00,
    PAGE_HI    = 2'b01,
    PAGE_AUTO  = 2'b10,
    PAGE_BLANK = 2'b11
  } page_sel_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK7 = 7'h7F;
  localparam logic [7:0] SEG_OFF    = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'hF;

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_0;
    unique case (nibble)
      4'h0: segs = SEG_0;
      4'h1: segs = SEG_1;
      4'h2: segs = SEG_2;
      4'h3: segs = SEG_3;
      4'h4: segs = SEG_4;
      4'h5: segs = SEG_5;
      4'h6: segs = SEG_6;
      4'h7: segs = SEG_7;
      4'h8: segs = SEG_8;
      4'h9: segs = SEG_9;
      4'hA: segs = SEG_A;
      4'hB: segs = SEG_B;
      4'hC: segs = SEG_C;
      4'hD: segs = SEG_D;
      4'hE: segs = SEG_E;
      4'hF: segs = SEG_F;
      default: segs = SEG_0;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit common-anode scan controller with paging, decimal points and blink.
// Define SEG_LZB_EN to enable leading-zero blanking within the displayed half.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned PAGE_FRAMES  = 250,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] disp_num,
  input  logic [1:0]  page_sel,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blink_mask,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int unsigned PreW   = $clog2(SCAN_DIV);
  localparam int unsigned PageW  = $clog2(PAGE_FRAMES + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PreW-1:0]   PreLast   = PreW'(SCAN_DIV - 1);
  localparam logic [PageW-1:0]  PageLast  = PageW'(PAGE_FRAMES - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

  logic [PreW-1:0]   pre_q;
  logic [1:0]        dig_q;
  logic [31:0]       sh_num_q;
  page_sel_e         sh_sel_q;
  logic [7:0]        sh_dp_q, sh_blink_q;
  logic              page_q, page_d;
  logic [PageW-1:0]  page_cnt_q, page_cnt_d;
  logic              blink_q, blink_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic              tick_q;

  logic       pre_end, boundary, page_eff, lz_blank;
  logic [2:0] nib_idx;
  logic [3:0] nibble;
  logic [6:0] hex_segs;
  page_sel_e  new_sel;

  assign pre_end  = (pre_q == PreLast);
  assign boundary = pre_end && (dig_q == 2'd3);
  assign new_sel  = page_sel_e'(page_sel);

  // Frame-rate counters; only committed on the frame boundary.
  always_comb begin
    page_d      = page_q;
    page_cnt_d  = page_cnt_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (new_sel == PAGE_AUTO && sh_sel_q != PAGE_AUTO) begin
      page_cnt_d = '0;
    end else if (sh_sel_q == PAGE_AUTO) begin
      if (page_cnt_q == PageLast) begin
        page_cnt_d = '0;
        page_d     = ~page_q;
      end else begin
        page_cnt_d = page_cnt_q + 1'b1;
      end
    end
    if (blink_cnt_q == BlinkLast) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_comb begin
    page_eff = (sh_sel_q == PAGE_HI) || (sh_sel_q == PAGE_AUTO && page_q);
    nib_idx  = {page_eff, dig_q};
    nibble   = sh_num_q[{nib_idx, 2'b00} +: 4];
  end

  seven_seg_hex_decode u_hex_decode (
    .nibble (nibble),
    .segs   (hex_segs)
  );

`ifdef SEG_LZB_EN
  logic [11:0] half_hi;
  assign half_hi = page_eff ? sh_num_q[31:20] : sh_num_q[15:4];

  // Slot k blanks only when it and every higher slot of the half are zero.
  always_comb begin
    unique case (dig_q)
      2'd3:    lz_blank = (half_hi[11:8] == 4'h0);
      2'd2:    lz_blank = (half_hi[11:4] == 8'h0);
      2'd1:    lz_blank = (half_hi == 12'h0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_d  = ~(4'b0001 << dig_q);
    seg_d = {~sh_dp_q[nib_idx], lz_blank ? SEG_BLANK7 : hex_segs};
    if (sh_sel_q == PAGE_BLANK) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end else if (blink_q && sh_blink_q[nib_idx]) begin
      seg_d = SEG_OFF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q       <= '0;
      dig_q       <= '0;
      sh_num_q    <= '0;
      sh_sel_q    <= PAGE_LO;
      sh_dp_q     <= '0;
      sh_blink_q  <= '0;
      page_q      <= 1'b0;
      page_cnt_q  <= '0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      tick_q      <= 1'b0;
    end else begin
      if (pre_end) begin
        pre_q <= '0;
        dig_q <= dig_q + 2'd1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      tick_q <= boundary;
      if (boundary) begin
        sh_num_q    <= disp_num;
        sh_sel_q    <= new_sel;
        sh_dp_q     <= dp_mask;
        sh_blink_q  <= blink_mask;
        page_q      <= page_d;
        page_cnt_q  <= page_cnt_d;
        blink_q     <= blink_d;
        blink_cnt_q <= blink_cnt_d;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Scan controller for the 4-digit, common-anode seven-segment display. It takes the 32-bit `disp_num` word from the display register and time-multiplexes it onto the board's anode and segment pins. It shows either half of the word, alternates between halves automatically, or blanks the display, with per-digit decimal-point and blink control. It sits between the display-register block and the top-level pins.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clk cycles per digit slot (≥2).
- `PAGE_FRAMES`, 250: frames per half in auto-page mode (≥1).
- `BLINK_FRAMES`, 125: frames per blink phase (≥1).

Ports:
- `clk`  in  1: system clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `disp_num`  in  32: value to display, eight hex nibbles.
- `page_sel`  in  2: 00 low half (nibbles 3..0); 01 high half (7..4); 10 auto-alternate; 11 blank.
- `dp_mask`  in  8: decimal point per nibble, 1 = lit.
- `blink_mask`  in  8: blink enable per nibble.
- `an`  out  4: anodes, active-low; `an[0]` is the rightmost digit.
- `seg`  out  8: active-low `{dp,g,f,e,d,c,b,a}`.
- `frame_tick`  out  1: one-cycle pulse at each frame boundary.

One clock, `clk`. `reset` is asynchronous and active-high.

## Operation
- Prescaler `pre` counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and `dig` (2 bits) increments, wrapping 3→0.
- Frame boundary is the cycle where `pre`=SCAN_DIV-1 and `dig`=3. On that edge, the following happen together:
  - `frame_tick` pulses.
  - `disp_num`, `page_sel`, `dp_mask` and `blink_mask` are captured into shadow registers.
  - Frame counters update.
- All display decisions use shadow values only; no tearing within a frame.
- Page flag:
  - Shadow sel 00 forces low; 01 forces high.
  - Shadow sel 10: the page counter counts frames and toggles the flag after PAGE_FRAMES frames, then restarts at 0.
  - The page counter holds when not in auto mode.
- Blink phase toggles every BLINK_FRAMES frames, free-running from reset.
- Nibble index n = {page, dig}. Decode:
  - Segment value = hex pattern of nibble n (see Test plan).
  - `dp` bit = ~dp_mask[n].
  - If blink phase=1 and blink_mask[n]=1, `seg`=8'hFF for that slot.
- Shadow sel 11: `an`=4'hF and `seg`=8'hFF.
- Otherwise `an` = one-hot-low of `dig`.
- `an` and `seg` are registered and change one cycle after `dig` changes.

## Timing
- Reset values:
  - `an`=4'hF, `seg`=8'hFF, `frame_tick`=0.
  - `pre`, `dig`, page flag, page counter, blink phase and blink counter all 0.
  - Shadows: 0, with shadow `page_sel`=00.
  - The first frame after reset displays 0000 on the low half.
- Digit slot is exactly SCAN_DIV cycles; frame is 4·SCAN_DIV cycles.
- Input-to-display latency: at most 4·SCAN_DIV+1 cycles (capture at the next boundary, plus one output register).
- Inputs changing mid-frame have no effect until the boundary. A change coincident with the boundary edge is captured.
- A `page_sel` change out of and back into 10 resets the page counter to 0. The page flag retains its value.
- Reset mid-frame: outputs blank asynchronously, and scanning restarts at digit 0 after release.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking within the displayed half.
  - A nibble in slot k>0 with value 0 is blanked (`seg` segments a–g off) when every higher slot in the half is also 0.
  - `an` still asserts for that slot, and the dp bit is still honoured.
  - Slot 0 is never blanked.
- Not defined: all four digits are always decoded.

## Structure
- Package `seven_seg_pkg` holds:
  - `page_sel` encodings: PAGE_LO, PAGE_HI, PAGE_AUTO, PAGE_BLANK.
  - The 16 active-low segment constants.
  - SEG_OFF=8'hFF and AN_OFF=4'hF.
- Sub-module `seven_seg_hex_decode`: combinational, 4-bit nibble → 7-bit active-low pattern. Instantiated once, fed by the muxed nibble.

## Test plan
Bench parameters: SCAN_DIV=4, PAGE_FRAMES=2, BLINK_FRAMES=2. Hex patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.

- **Reset and low page:** reset, then `disp_num`=32'h12345678, `page_sel`=00. In the second frame:
  - dig0: `an`=1110, `seg`=80.
  - dig1: `an`=1101, `seg`=F8.
  - dig2: `an`=1011, `seg`=82.
  - dig3: `an`=0111, `seg`=92.
  - `frame_tick` pulses every 16 cycles.
- **High page with decimal point:** `page_sel`=01, `dp_mask`=8'h10. The next frame shows dig0 `seg`=19 (4 with dp), and dig3 `seg`=F9.
- **Auto page:** `page_sel`=10. Displayed halves follow low, low, high, high, low… frame by frame.
- **Blink and blank:** `blink_mask`=8'h01. dig0 reads `seg`=FF in alternate frame pairs. Then `page_sel`=11: `an`=F and `seg`=FF for the whole next frame.
- **Leading-zero blanking:** `disp_num`=32'h00000012, low page.
  - With `SEG_LZB_EN`: dig3 and dig2 `seg`=FF with `an` active; dig1=F9, dig0=A4.
  - Without: dig3=C0.
- **Reset mid-frame:** assert `reset` during dig2. `an`=F and `seg`=FF within the same cycle. After release, scanning restarts at dig0, and the first `frame_tick` comes 16 cycles later.
